// File: rtl/nco_freq_sweep.sv
//-----------------------------------------------------------------------------
// NcoFreqSweep (module nco_freq_sweep)
//
// Purpose:
//   Generates the NCO phase increment for stepped-frequency operation. On an
//   accepted start the sweep configuration is captured, and phase_inc walks
//   from f_start towards f_stop in increments of f_step. Each value is held
//   for max(dwell,1) clken ticks. When the next step would pass f_stop,
//   overflow the phase word, or f_step is zero, the sweep either restarts at
//   f_start (repeat mode) or parks in DONE with the last value held.
//
// Ports:
//   CLK          system clock
//   reset_n      asynchronous active-low reset
//   clken        12.5 MHz tick enable; all sweep progress is gated by it
//   start        begin a sweep (honoured only in IDLE or DONE, on a tick)
//   abort        return to IDLE on any CLK edge, highest priority
//   repeat_en    0 = single sweep, 1 = restart at f_start after the end
//   f_start      first phase increment
//   f_stop       inclusive upper limit of the sweep
//   f_step       unsigned increment per step
//   dwell        ticks per frequency (0 behaves as 1)
//   phase_inc    registered phase increment to the NCO
//   busy         high while sweeping (DWELL)
//   step_strobe  one-CLK pulse when phase_inc advances to a new step
//   wrap_strobe  one-CLK pulse when a repeat sweep reloads f_start
//   done         high in DONE
//   step_index   current step number, 0 at f_start
//-----------------------------------------------------------------------------
module nco_freq_sweep #(
  parameter int PHASE_W = 32,
  parameter int DWELL_W = 18,
  parameter int IDX_W   = 16
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic               clken,
  input  logic               start,
  input  logic               abort,
  input  logic               repeat_en,
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_stop,
  input  logic [PHASE_W-1:0] f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               busy,
  output logic               step_strobe,
  output logic               wrap_strobe,
  output logic               done,
  output logic [IDX_W-1:0]   step_index
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } sweepState_e;

  sweepState_e        state_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [PHASE_W-1:0] phaseInc_q;
  logic [IDX_W-1:0]   stepIndex_q;
  logic               busy_q;
  logic               done_q;
  logic               stepStrobe_q;
  logic               wrapStrobe_q;

  // Configuration captured on an accepted start
  logic [PHASE_W-1:0] fStart_q;
  logic [PHASE_W-1:0] fStop_q;
  logic [PHASE_W-1:0] fStep_q;
  logic [DWELL_W-1:0] dwellReload_q;
  logic               repeatEn_q;

  logic [PHASE_W:0]   stepSum_d;
  logic               sweepEnd_d;
  logic [DWELL_W-1:0] dwellReload_d;

  // The candidate next frequency is formed one bit wider so that a phase
  // word overflow is visible as a carry rather than a silent wrap to a small
  // value. A zero step would otherwise repeat the same frequency forever, so
  // it is treated as the end of the sweep too.
  assign stepSum_d  = {1'b0, phaseInc_q} + {1'b0, fStep_q};
  assign sweepEnd_d = stepSum_d[PHASE_W]
                    | (stepSum_d[PHASE_W-1:0] > fStop_q)
                    | (fStep_q == '0);

  // Counter reload is dwell-1 so that a value is held for exactly dwell
  // ticks; dwell of 0 folds onto 1 (reload of 0).
  assign dwellReload_d = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

  // Single sequential block for the sweep FSM, its datapath and the
  // registered status outputs. Strobes default low every edge so they are
  // one CLK wide and stay low while clken is low.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      phaseInc_q    <= '0;
      stepIndex_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stepStrobe_q  <= 1'b0;
      wrapStrobe_q  <= 1'b0;
      fStart_q      <= '0;
      fStop_q       <= '0;
      fStep_q       <= '0;
      dwellReload_q <= '0;
      repeatEn_q    <= 1'b0;
    end else begin
      stepStrobe_q <= 1'b0;
      wrapStrobe_q <= 1'b0;

      if (abort) begin
        // Abort wins over everything, including a start on the same edge,
        // and does not wait for a tick. phase_inc and step_index keep their
        // values so the NCO keeps a defined frequency.
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (clken) begin
        unique case (state_q)
          IDLE, DONE: begin
            if (start) begin
              fStart_q      <= f_start;
              fStop_q       <= f_stop;
              fStep_q       <= f_step;
              dwellReload_q <= dwellReload_d;
              repeatEn_q    <= repeat_en;
              phaseInc_q    <= f_start;
              stepIndex_q   <= '0;
              cnt_q         <= dwellReload_d;
              state_q       <= DWELL;
              busy_q        <= 1'b1;
              done_q        <= 1'b0;
            end
          end

          DWELL: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - DWELL_W'(1);
            end else if (!sweepEnd_d) begin
              phaseInc_q   <= stepSum_d[PHASE_W-1:0];
              stepIndex_q  <= stepIndex_q + IDX_W'(1);
              stepStrobe_q <= 1'b1;
              cnt_q        <= dwellReload_q;
            end else if (repeatEn_q) begin
              phaseInc_q   <= fStart_q;
              stepIndex_q  <= '0;
              wrapStrobe_q <= 1'b1;
              cnt_q        <= dwellReload_q;
            end else begin
              // Single sweep finished: the last frequency stays on the NCO.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end

          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign phase_inc   = phaseInc_q;
  assign busy        = busy_q;
  assign step_strobe = stepStrobe_q;
  assign wrap_strobe = wrapStrobe_q;
  assign done        = done_q;
  assign step_index  = stepIndex_q;

endmodule
